branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
Parametrised branch target buffer with per-entry saturating direction counters. It sits in the IF stage beside the PC register. It supplies a predicted next PC in the same cycle as fetch, and is trained from the ID-stage branch/jump resolution (Branch, Jump, BTB_Addr, Jump_Addr). This generalises the fixed, always-not-taken ID-stage branch handling to N-entry, direct-mapped, tagged prediction with mispredict statistics.

Parameters:
ENTRIES, 16, number of table entries; power of 2, minimum 2; IDX_W = log2(ENTRIES).
ADDR_W, 32, PC and target width.
CNT_W, 2, direction counter width; minimum 1.
STAT_W, 16, width of each statistics counter.

Ports:
CLK  in  1  clock, rising edge.
RESET  in  1  asynchronous, active-low reset.
IF_PC  in  ADDR_W  fetch PC to look up.
Pred_Hit  out  1  valid entry with matching tag at IF_PC.
Pred_Taken  out  1  Pred_Hit AND counter MSB = 1.
Pred_Target  out  ADDR_W  stored target when Pred_Taken, else IF_PC+4.
Upd_Valid  in  1  ID stage resolved a control instruction this cycle.
Upd_PC  in  ADDR_W  PC of the resolved instruction.
Upd_Taken  in  1  actual outcome.
Upd_Target  in  ADDR_W  actual target (BTB_Addr or Jump_Addr).
Upd_Pred_Taken  in  1  prediction that was made for this instruction in IF.
Flush_All  in  1  invalidate the whole table.
Mispredict  out  1  registered; pulses 1 cycle after an update whose outcome disagreed with the prediction.
Lookup_Cnt  out  STAT_W  count of update events.
Mispred_Cnt  out  STAT_W  count of mispredicts.

Behaviour:
- Index = PC[IDX_W+1:2]. Tag = PC[ADDR_W-1:IDX_W+2]. PC[1:0] is ignored.
- Per entry: valid bit, tag, target, CNT_W-bit counter.
- Lookup is combinational from IF_PC, with zero latency. Table state changes only on the rising CLK edge.
- Update, on a rising edge with Upd_Valid=1:
  - Hit (entry valid, tag equal): counter +1 if Upd_Taken, -1 otherwise, saturating at 0 and 2^CNT_W-1. If Upd_Taken, target <= Upd_Target.
  - Miss with Upd_Taken=1: allocate the entry (overwrite any prior occupant). Set valid=1, tag, target. Counter = 2^(CNT_W-1), i.e. weakly taken.
  - Miss with Upd_Taken=0: no table change.
- Mispredict is registered. It is 1 one cycle after an update where (Upd_Taken != Upd_Pred_Taken) OR (Upd_Taken AND Upd_Pred_Taken AND stored target before update != Upd_Target). Otherwise 0.
- Lookup_Cnt +1 per Upd_Valid edge. Mispred_Cnt +1 per mispredict edge. Both saturate at 2^STAT_W-1 and never wrap.
- Flush_All: all valid bits <= 0 at the edge. It overrides a simultaneous update, so no allocation occurs. Flush_All does not clear the statistics counters, and the Mispredict evaluation still occurs.
- Simultaneous lookup and update to the same index: lookup returns the pre-edge contents (no bypass) unless BTB_BYPASS_EN is defined.
- Reset (RESET=0, asynchronous): all valid=0, counters=0, targets=0, tags=0, Mispredict=0, Lookup_Cnt=0, Mispred_Cnt=0. Therefore Pred_Hit=0, Pred_Taken=0 and Pred_Target=IF_PC+4 immediately.
- Reset asserted mid-update discards the update.
- IF_PC+4 wraps modulo 2^ADDR_W.

Optional Feature:
BTB_BYPASS_EN:
- Defined: when Upd_Valid=1 and Upd_PC index and tag equal IF_PC in the same cycle, outputs reflect the post-update entry combinationally: the next counter MSB, and Upd_Target if allocating or taken. If Flush_All=1 in that cycle, Pred_Hit=0.
- Undefined: no bypass; lookup sees registered state only.

Test Plan:
1. Reset then IF_PC=0x40 -> Pred_Hit=0, Pred_Taken=0, Pred_Target=0x44, all counters 0.
2. Update PC=0x40, taken, target=0x100, Upd_Pred_Taken=0; next cycle IF_PC=0x40 -> Pred_Hit=1, Pred_Taken=1, Pred_Target=0x100, Mispredict=1, Mispred_Cnt=1.
3. Two not-taken updates at 0x40 -> counter 2->1->0. Lookup gives Pred_Hit=1, Pred_Taken=0, Pred_Target=0x44. Four taken updates -> counter saturates at 3.
4. Aliasing (ENTRIES=16): allocate 0x40, then taken update at 0x80 (same index 0, different tag) -> IF_PC=0x40 gives Pred_Hit=0; IF_PC=0x80 hits.
5. Flush_All=1 together with a taken update at 0x20 -> no entries valid after the edge, and Lookup_Cnt still increments.
6. Same-cycle update and lookup at 0x40 (miss, taken, target 0x200): without the macro Pred_Hit=0 that cycle; with BTB_BYPASS_EN, Pred_Hit=1 and Pred_Target=0x200. Also assert RESET mid-stream -> outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged BTB with saturating direction counters and mispredict statistics.
// Lookup is combinational with zero latency; training and stats update on CLK; Mispredict is registered (1 cycle). No backpressure.
// Optional macro BTB_BYPASS_EN forwards a same-cycle update to a matching lookup.
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] IF_PC,
    output logic              Pred_Hit,
    output logic              Pred_Taken,
    output logic [ADDR_W-1:0] Pred_Target,
    input  logic              Upd_Valid,
    input  logic [ADDR_W-1:0] Upd_PC,
    input  logic              Upd_Taken,
    input  logic [ADDR_W-1:0] Upd_Target,
    input  logic              Upd_Pred_Taken,
    input  logic              Flush_All,
    output logic              Mispredict,
    output logic [STAT_W-1:0] Lookup_Cnt,
    output logic [STAT_W-1:0] Mispred_Cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_WEAK = CNT_W'(2 ** (CNT_W - 1));
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_d [ENTRIES];
    logic [CNT_W-1:0]   cnt_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_d [ENTRIES];
    logic               mispred_q, mispred_d;
    logic [STAT_W-1:0]  lookup_cnt_q, lookup_cnt_d;
    logic [STAT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0] if_tag, upd_tag;
    logic             upd_hit;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [ADDR_W-1:0] rd_tgt;
    logic [CNT_W-1:0] rd_cnt;
    logic             unused_low_bits;

    assign if_idx  = IF_PC[IDX_W+1:2];
    assign if_tag  = IF_PC[ADDR_W-1:IDX_W+2];
    assign upd_idx = Upd_PC[IDX_W+1:2];
    assign upd_tag = Upd_PC[ADDR_W-1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign unused_low_bits = ^{IF_PC[1:0], Upd_PC[1:0]};

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (Flush_All) begin
            valid_d = '0;
        end else if (Upd_Valid) begin
            if (upd_hit) begin
                if (Upd_Taken) begin
                    tgt_d[upd_idx] = Upd_Target;
                    if (cnt_q[upd_idx] != CNT_MAX)
                        cnt_d[upd_idx] = cnt_q[upd_idx] + CNT_W'(1);
                end else if (cnt_q[upd_idx] != '0) begin
                    cnt_d[upd_idx] = cnt_q[upd_idx] - CNT_W'(1);
                end
            end else if (Upd_Taken) begin
                valid_d[upd_idx] = 1'b1;
                tag_d[upd_idx]   = upd_tag;
                tgt_d[upd_idx]   = Upd_Target;
                cnt_d[upd_idx]   = CNT_WEAK;
            end
        end
    end

    // Mispredict compares against the pre-update target, even when flushing.
    always_comb begin
        mispred_d = Upd_Valid &&
                    ((Upd_Taken != Upd_Pred_Taken) ||
                     (Upd_Taken && Upd_Pred_Taken && (tgt_q[upd_idx] != Upd_Target)));
        lookup_cnt_d  = lookup_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (Upd_Valid && (lookup_cnt_q != STAT_MAX))
            lookup_cnt_d = lookup_cnt_q + STAT_W'(1);
        if (mispred_d && (mispred_cnt_q != STAT_MAX))
            mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end

`ifdef BTB_BYPASS_EN
    logic byp;
    assign byp = RESET && Upd_Valid && (Upd_PC[ADDR_W-1:2] == IF_PC[ADDR_W-1:2]);
    always_comb begin
        rd_valid = byp ? valid_d[if_idx] : valid_q[if_idx];
        rd_tag   = byp ? tag_d[if_idx]   : tag_q[if_idx];
        rd_tgt   = byp ? tgt_d[if_idx]   : tgt_q[if_idx];
        rd_cnt   = byp ? cnt_d[if_idx]   : cnt_q[if_idx];
    end
`else
    always_comb begin
        rd_valid = valid_q[if_idx];
        rd_tag   = tag_q[if_idx];
        rd_tgt   = tgt_q[if_idx];
        rd_cnt   = cnt_q[if_idx];
    end
`endif

    assign Pred_Hit    = rd_valid && (rd_tag == if_tag);
    assign Pred_Taken  = Pred_Hit && rd_cnt[CNT_W-1];
    assign Pred_Target = Pred_Taken ? rd_tgt : IF_PC + ADDR_W'(4);
    assign Mispredict  = mispred_q;
    assign Lookup_Cnt  = lookup_cnt_q;
    assign Mispred_Cnt = mispred_cnt_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q       <= '0;
            mispred_q     <= 1'b0;
            lookup_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            tgt_q         <= tgt_d;
            cnt_q         <= cnt_d;
            mispred_q     <= mispred_d;
            lookup_cnt_q  <= lookup_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: vector table with post-edge scoreboard, plus reset and stat saturation sequences.
module tb_branch_target_buffer;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IF_PC, Upd_PC, Upd_Target;
    logic        Upd_Valid, Upd_Taken, Upd_Pred_Taken, Flush_All;
    logic        Pred_Hit, Pred_Taken, Mispredict;
    logic [31:0] Pred_Target;
    logic [15:0] Lookup_Cnt, Mispred_Cnt;

    logic        unused_hit2, unused_taken2, unused_mis2;
    logic [31:0] unused_tgt2;
    logic [1:0]  lcnt2, mcnt2;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    branch_target_buffer dut (
        .CLK(CLK), .RESET(RESET), .IF_PC(IF_PC),
        .Pred_Hit(Pred_Hit), .Pred_Taken(Pred_Taken), .Pred_Target(Pred_Target),
        .Upd_Valid(Upd_Valid), .Upd_PC(Upd_PC), .Upd_Taken(Upd_Taken),
        .Upd_Target(Upd_Target), .Upd_Pred_Taken(Upd_Pred_Taken), .Flush_All(Flush_All),
        .Mispredict(Mispredict), .Lookup_Cnt(Lookup_Cnt), .Mispred_Cnt(Mispred_Cnt)
    );

    // Narrow statistics counters to reach saturation quickly.
    branch_target_buffer #(.STAT_W(2)) dut_sat (
        .CLK(CLK), .RESET(RESET), .IF_PC(IF_PC),
        .Pred_Hit(unused_hit2), .Pred_Taken(unused_taken2), .Pred_Target(unused_tgt2),
        .Upd_Valid(Upd_Valid), .Upd_PC(Upd_PC), .Upd_Taken(Upd_Taken),
        .Upd_Target(Upd_Target), .Upd_Pred_Taken(Upd_Pred_Taken), .Flush_All(Flush_All),
        .Mispredict(unused_mis2), .Lookup_Cnt(lcnt2), .Mispred_Cnt(mcnt2)
    );

    typedef struct {
        logic [31:0] if_pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic        fl;
        logic        ehit;
        logic        etk;
        logic [31:0] etgt;
        logic        emis;
        logic [15:0] elc;
        logic [15:0] emc;
    } vec_t;

    typedef struct {
        int          id;
        logic        emis;
        logic [15:0] elc;
        logic [15:0] emc;
    } post_t;

    vec_t  vecs[24];
    post_t sbq[$];

    function automatic vec_t mk(input logic [31:0] if_pc, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt, input logic upt,
                                input logic fl, input logic ehit, input logic etk,
                                input logic [31:0] etgt, input logic emis,
                                input logic [15:0] elc, input logic [15:0] emc);
        vec_t v;
        v.if_pc = if_pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt;
        v.fl = fl; v.ehit = ehit; v.etk = etk; v.etgt = etgt; v.emis = emis;
        v.elc = elc; v.emc = emc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        post_t p;
        RESET = 1'b0; IF_PC = 32'h40; Upd_Valid = 0; Upd_PC = 0; Upd_Taken = 0;
        Upd_Target = 0; Upd_Pred_Taken = 0; Flush_All = 0;

        //            if_pc        uv upc      ut utgt     upt fl hit tk tgt          mis lc  mc
        vecs[0]  = mk(32'h40,       0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h44,      0,  0,  0);
        vecs[1]  = mk(32'h40,       1, 32'h40, 1, 32'h100, 0, 0, 0, 0, 32'h44,      1,  1,  1);
        vecs[2]  = mk(32'h40,       0, 32'h0,  0, 32'h0,   0, 0, 1, 1, 32'h100,     0,  1,  1);
        vecs[3]  = mk(32'h40,       1, 32'h40, 0, 32'h0,   1, 0, 1, 1, 32'h100,     1,  2,  2);
        vecs[4]  = mk(32'h40,       1, 32'h40, 0, 32'h0,   0, 0, 1, 0, 32'h44,      0,  3,  2);
        vecs[5]  = mk(32'h40,       1, 32'h40, 1, 32'h100, 0, 0, 1, 0, 32'h44,      1,  4,  3);
        vecs[6]  = mk(32'h40,       1, 32'h40, 1, 32'h100, 0, 0, 1, 0, 32'h44,      1,  5,  4);
        vecs[7]  = mk(32'h40,       1, 32'h40, 1, 32'h100, 1, 0, 1, 1, 32'h100,     0,  6,  4);
        vecs[8]  = mk(32'h40,       1, 32'h40, 1, 32'h100, 1, 0, 1, 1, 32'h100,     0,  7,  4);
        vecs[9]  = mk(32'h40,       1, 32'h40, 0, 32'h0,   1, 0, 1, 1, 32'h100,     1,  8,  5);
        vecs[10] = mk(32'h40,       0, 32'h0,  0, 32'h0,   0, 0, 1, 1, 32'h100,     0,  8,  5);
        vecs[11] = mk(32'h40,       1, 32'h40, 1, 32'h180, 1, 0, 1, 1, 32'h100,     1,  9,  6);
        vecs[12] = mk(32'h40,       1, 32'h80, 1, 32'h300, 0, 0, 1, 1, 32'h180,     1, 10,  7);
        vecs[13] = mk(32'h40,       0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h44,      0, 10,  7);
        vecs[14] = mk(32'h80,       0, 32'h0,  0, 32'h0,   0, 0, 1, 1, 32'h300,     0, 10,  7);
        vecs[15] = mk(32'h24,       1, 32'h24, 0, 32'h0,   0, 0, 0, 0, 32'h28,      0, 11,  7);
        vecs[16] = mk(32'h24,       0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h28,      0, 11,  7);
        vecs[17] = mk(32'h80,       1, 32'h20, 1, 32'h400, 0, 1, 1, 1, 32'h300,     1, 12,  8);
        vecs[18] = mk(32'h20,       0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h24,      0, 12,  8);
        vecs[19] = mk(32'h80,       0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h84,      0, 12,  8);
        vecs[20] = mk(32'hFFFFFFFC, 0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h0,       0, 12,  8);
`ifdef BTB_BYPASS_EN
        vecs[21] = mk(32'h40,       1, 32'h40, 1, 32'h200, 0, 0, 1, 1, 32'h200,     1, 13,  9);
`else
        vecs[21] = mk(32'h40,       1, 32'h40, 1, 32'h200, 0, 0, 0, 0, 32'h44,      1, 13,  9);
`endif
        vecs[22] = mk(32'h40,       0, 32'h0,  0, 32'h0,   0, 0, 1, 1, 32'h200,     0, 13,  9);
        vecs[23] = mk(32'h40,       1, 32'h40, 0, 32'h0,   1, 0, 1, 1, 32'h200,     1, 14, 10);

        #1;
        chk("reset_hit", 32'(Pred_Hit), 32'd0);
        chk("reset_target", Pred_Target, 32'h44);
        chk("reset_lookup_cnt", 32'(Lookup_Cnt), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge CLK);
            IF_PC = vecs[i].if_pc; Upd_Valid = vecs[i].uv; Upd_PC = vecs[i].upc;
            Upd_Taken = vecs[i].ut; Upd_Target = vecs[i].utgt;
            Upd_Pred_Taken = vecs[i].upt; Flush_All = vecs[i].fl;
            #1;
            chk($sformatf("v%0d_hit", i), 32'(Pred_Hit), 32'(vecs[i].ehit));
            chk($sformatf("v%0d_taken", i), 32'(Pred_Taken), 32'(vecs[i].etk));
            chk($sformatf("v%0d_target", i), Pred_Target, vecs[i].etgt);
            sbq.push_back('{id: i, emis: vecs[i].emis, elc: vecs[i].elc, emc: vecs[i].emc});
            @(posedge CLK);
            #1;
            p = sbq.pop_front();
            chk($sformatf("v%0d_mispredict", p.id), 32'(Mispredict), 32'(p.emis));
            chk($sformatf("v%0d_lookup_cnt", p.id), 32'(Lookup_Cnt), 32'(p.elc));
            chk($sformatf("v%0d_mispred_cnt", p.id), 32'(Mispred_Cnt), 32'(p.emc));
        end

        @(negedge CLK);
        Upd_Valid = 0; Flush_All = 0; IF_PC = 32'h40;
        #1;
        chk("sat_lookup_cnt", 32'(lcnt2), 32'd3);
        chk("sat_mispred_cnt", 32'(mcnt2), 32'd3);
        chk("pre_reset_hit", 32'(Pred_Hit), 32'd1);
        chk("pre_reset_mispredict", 32'(Mispredict), 32'd1);
        #1 RESET = 1'b0;
        #1;
        chk("async_reset_hit", 32'(Pred_Hit), 32'd0);
        chk("async_reset_taken", 32'(Pred_Taken), 32'd0);
        chk("async_reset_target", Pred_Target, 32'h44);
        chk("async_reset_mispredict", 32'(Mispredict), 32'd0);
        chk("async_reset_lookup_cnt", 32'(Lookup_Cnt), 32'd0);
        chk("async_reset_mispred_cnt", 32'(Mispred_Cnt), 32'd0);
        Upd_Valid = 1; Upd_PC = 32'h40; Upd_Taken = 1; Upd_Target = 32'h500; Upd_Pred_Taken = 0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1; Upd_Valid = 0;
        #1;
        chk("reset_discard_hit", 32'(Pred_Hit), 32'd0);
        chk("reset_discard_lookup_cnt", 32'(Lookup_Cnt), 32'd0);
        chk("reset_discard_mispredict", 32'(Mispredict), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
